// File: rtl/fifo_arbiter_if.sv
// rtl/fifo_arbiter_if.sv - handshake bundle between the arbiter and the shared fifo
interface fifo_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             o_fifo_set;
    logic             o_fifo_get;
    logic [WIDTH-1:0] o_fifo_data;
    logic             i_fifo_set;
    logic             i_fifo_get;
    logic [WIDTH-1:0] i_fifo_data;

    modport master (
        output o_fifo_set, o_fifo_get, o_fifo_data,
        input  i_fifo_set, i_fifo_get, i_fifo_data
    );

    modport slave (
        input  o_fifo_set, o_fifo_get, o_fifo_data,
        output i_fifo_set, i_fifo_get, i_fifo_data
    );
endinterface

// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - round-robin arbiter sharing one pulse-handshake fifo between two requesters
module fifo_arbiter #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 15
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [1:0]             i_req,
    input  logic [1:0]             i_op,
    input  logic [2*WIDTH-1:0]     i_wdata,
    output logic [1:0]             o_ack,
    output logic [1:0]             o_err,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_fault,
    fifo_arbiter_if.master         fifo
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic             ptr, gnt_q, gnt_n;
    logic             op_q, err_q;
    logic [WIDTH-1:0] wdata_q;
    logic [TW-1:0]    tcnt;
    logic [1:0]       eligible;
    logic             any_req, op_sel, illegal, ack_in, timeout_hit, grant;

    always_comb begin
        eligible    = i_req & ~o_ack & ~o_err;
        any_req     = |eligible;
        gnt_n       = eligible[ptr] ? ptr : ~ptr;
        op_sel      = i_op[gnt_n];
        illegal     = op_sel ? o_full : o_empty;
        grant       = (state == IDLE) && i_en && any_req;
        ack_in      = op_q ? fifo.i_fifo_set : fifo.i_fifo_get;
        timeout_hit = (tcnt == TW'(TIMEOUT - 1));

        state_n = state;
        case (state)
            IDLE:    if (grant) state_n = illegal ? DONE : ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (ack_in || timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            tcnt    <= '0;
            o_count <= '0;
            o_rdata <= '0;
            o_fault <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_q   <= gnt_n;
                        ptr     <= ~gnt_n;
                        op_q    <= op_sel;
                        err_q   <= illegal;
                        wdata_q <= gnt_n ? i_wdata[2*WIDTH-1:WIDTH] : i_wdata[WIDTH-1:0];
                    end
                end
                ISSUE: tcnt <= '0;
                WAIT: begin
                    // A late ack wins over a timeout landing in the same cycle.
                    if (ack_in) begin
                        err_q <= 1'b0;
                        if (op_q) begin
                            o_count <= o_count + CW'(1);
                        end else begin
                            o_count <= o_count - CW'(1);
                            o_rdata <= fifo.i_fifo_data;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        o_fault <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_full           = (o_count == CW'(DEPTH));
        o_empty          = (o_count == '0);
        o_ack            = 2'b00;
        o_err            = 2'b00;
        if (state == DONE) begin
            if (err_q) o_err = gnt_q ? 2'b10 : 2'b01;
            else       o_ack = gnt_q ? 2'b10 : 2'b01;
        end
        fifo.o_fifo_set  = (state == ISSUE) && op_q;
        fifo.o_fifo_get  = (state == ISSUE) && !op_q;
        fifo.o_fifo_data = wdata_q;
    end
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb/tb_fifo_arbiter.sv - directed vector bench for fifo_arbiter with a behavioural fifo model
module tb_fifo_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  op = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  ack, err;
    logic [7:0]  rdata;
    logic [2:0]  count;
    logic        full, empty, fault;

    fifo_arbiter_if #(.WIDTH(8)) fif ();

    fifo_arbiter #(.WIDTH(8), .DEPTH(4), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_op(op), .i_wdata(wdata),
        .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_count(count),
        .o_full(full), .o_empty(empty), .o_fault(fault), .fifo(fif)
    );

    always #5 clk = ~clk;

    // Behavioural fifo: acks one cycle after the strobe unless stalled.
    logic [7:0] q[$];
    bit  pend_set = 0, pend_get = 0, stall = 0;
    int  strobes = 0;

    initial begin
        fif.i_fifo_set  = 1'b0;
        fif.i_fifo_get  = 1'b0;
        fif.i_fifo_data = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pend_set = 0;
            pend_get = 0;
            fif.i_fifo_set = 1'b0;
            fif.i_fifo_get = 1'b0;
        end else begin
            fif.i_fifo_set = pend_set;
            fif.i_fifo_get = pend_get;
            if (pend_get && q.size() > 0) fif.i_fifo_data = q.pop_front();
            pend_set = fif.o_fifo_set && !stall;
            pend_get = fif.o_fifo_get && !stall;
            if (pend_set) q.push_back(fif.o_fifo_data);
            if (fif.o_fifo_set || fif.o_fifo_get) strobes++;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int r, input bit opv, input logic [7:0] d,
                           output int lat, output bit got_ack, output bit got_err, output int nstr);
        int s0;
        @(posedge clk); @(negedge clk);
        s0 = strobes;
        req[r] = 1'b1;
        op[r]  = opv;
        wdata[r*8 +: 8] = d;
        lat = 0; got_ack = 0; got_err = 0;
        while (lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (ack[r] || err[r]) begin
                got_ack = ack[r];
                got_err = err[r];
                break;
            end
        end
        req[r] = 1'b0;
        nstr = strobes - s0;
    endtask

    typedef struct {
        int         r;
        bit         op;
        logic [7:0] d;
        bit         exp_err;
        int         exp_lat;
        logic [7:0] exp_rdata;
        int         exp_count;
        int         exp_str;
    } vec_t;

    vec_t vecs[13];
    int   lat, nstr, cyc, n;
    bit   ga, ge;
    int   seq[4], ts[4];

    initial begin
        vecs[0]  = '{0, 1, 8'h5A, 0, 3, 8'h00, 1, 1};
        vecs[1]  = '{0, 0, 8'h00, 0, 3, 8'h5A, 0, 1};
        vecs[2]  = '{1, 0, 8'h00, 1, 1, 8'h00, 0, 0};
        vecs[3]  = '{0, 1, 8'h01, 0, 3, 8'h00, 1, 1};
        vecs[4]  = '{1, 1, 8'h02, 0, 3, 8'h00, 2, 1};
        vecs[5]  = '{0, 1, 8'h03, 0, 3, 8'h00, 3, 1};
        vecs[6]  = '{1, 1, 8'h04, 0, 3, 8'h00, 4, 1};
        vecs[7]  = '{0, 1, 8'h05, 1, 1, 8'h00, 4, 0};
        vecs[8]  = '{1, 0, 8'h00, 0, 3, 8'h01, 3, 1};
        vecs[9]  = '{0, 0, 8'h00, 0, 3, 8'h02, 2, 1};
        vecs[10] = '{1, 0, 8'h00, 0, 3, 8'h03, 1, 1};
        vecs[11] = '{0, 0, 8'h00, 0, 3, 8'h04, 0, 1};
        vecs[12] = '{1, 0, 8'h00, 1, 1, 8'h00, 0, 0};

        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ack_err", {ack, err}, 0);
        chk("rst_fault", fault, 0);
        chk("rst_strobes", {fif.o_fifo_set, fif.o_fifo_get}, 0);
        chk("rst_rdata", rdata, 0);
        #11 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].r, vecs[i].op, vecs[i].d, lat, ga, ge, nstr);
            chk($sformatf("v%0d_ack", i), ga, !vecs[i].exp_err);
            chk($sformatf("v%0d_err", i), ge, vecs[i].exp_err);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("v%0d_full", i), full, vecs[i].exp_count == 4);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].exp_count == 0);
            chk($sformatf("v%0d_strobes", i), nstr, vecs[i].exp_str);
            if (!vecs[i].op && !vecs[i].exp_err)
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        chk("rdata_held", rdata, 8'h04);

        // i_en low: a held request is ignored.
        @(negedge clk);
        en = 1'b0; nstr = strobes;
        req[0] = 1'b1; op[0] = 1'b1; wdata[7:0] = 8'hEE;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack != 0 || err != 0) n++;
        end
        chk("en_low_no_ack", n, 0);
        chk("en_low_no_strobe", strobes - nstr, 0);
        req = '0; en = 1'b1;

        // Contention: both push continuously; pointer is at r0 after v12 granted r1.
        @(negedge clk); @(negedge clk);
        op = 2'b11; wdata = {8'hB1, 8'hA1}; req = 2'b11;
        cyc = 0; n = 0;
        while (cyc < 60 && n < 4) begin
            @(negedge clk);
            cyc++;
            if (ack != 0) begin
                seq[n] = ack[1] ? 1 : 0;
                ts[n]  = cyc;
                n++;
            end
        end
        req = '0;
        chk("cont_acks", n, 4);
        if (n == 4) begin
            chk("cont_seq", {seq[0][1:0], seq[1][1:0], seq[2][1:0], seq[3][1:0]}, 8'b00_01_00_01);
            chk("cont_r0_period", ts[2] - ts[0], 8);
            chk("cont_r1_period", ts[3] - ts[1], 8);
        end
        chk("cont_count", count, 4);
        chk("cont_q0", (q.size() == 4) ? {q[0], q[1], q[2], q[3]} : 32'h0, 32'hA1B1A1B1);

        // Reset during WAIT.
        run_txn(0, 0, 8'h00, lat, ga, ge, nstr);
        chk("pre_rst_pop", rdata, 8'hA1);
        chk("pre_rst_count", count, 3);
        stall = 1;
        @(posedge clk); @(negedge clk);
        req[0] = 1'b1; op[0] = 1'b1; wdata[7:0] = 8'h77;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_outs", {ack, err, fif.o_fifo_set, fif.o_fifo_get, fault}, 0);
        chk("mid_rst_rdata", rdata, 0);
        req = '0; stall = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        run_txn(0, 1, 8'h33, lat, ga, ge, nstr);
        chk("post_rst_ack", ga, 1);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_count", count, 1);

        // Timeout: fifo never acks the push.
        stall = 1;
        run_txn(1, 1, 8'h44, lat, ga, ge, nstr);
        chk("to_err", ge, 1);
        chk("to_lat", lat, 17);
        chk("to_fault", fault, 1);
        chk("to_count", count, 1);
        chk("to_strobe", nstr, 1);
        stall = 0;
        run_txn(0, 0, 8'h00, lat, ga, ge, nstr);
        chk("after_to_ack", ga, 1);
        chk("after_to_rdata", rdata, 8'h33);
        chk("after_to_count", count, 0);
        chk("fault_sticky", fault, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Shares one `fifo` instance (WIDTH x DEPTH; pulse handshake i_set/i_get, ack o_set/o_get) between two requesters, e.g. the Forth core and a debug/loader port.
- Serialises push/pop transactions with round-robin arbitration.
- Tracks occupancy, since the FIFO exposes no full/empty.
- Rejects push-when-full and pop-when-empty, and detects a FIFO that never acknowledges.

Parameters:
- WIDTH, 8, data bits; must match the FIFO.
- DEPTH, 256, FIFO cells; must match the FIFO.
- TIMEOUT, 15, max cycles spent in WAIT before fault.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  new grants allowed only when high.
- i_req  in  2  per-requester request level; held until o_ack or o_err for that requester.
- i_op  in  2  per-requester op: 1 = push, 0 = pop; stable while i_req is high.
- i_wdata  in  2*WIDTH  push data; requester n uses bits [n*WIDTH +: WIDTH].
- o_ack  out  2  one-cycle completion pulse, per requester.
- o_err  out  2  one-cycle rejection pulse (full/empty/timeout), per requester.
- o_rdata  out  WIDTH  pop data; valid in the o_ack cycle, held until the next pop completes.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.
- o_fault  out  1  sticky; set on timeout.
- o_fifo_set  out  1  drives fifo i_set.
- o_fifo_get  out  1  drives fifo i_get.
- o_fifo_data  out  WIDTH  drives fifo i_data.
- i_fifo_set  in  1  from fifo o_set (push ack).
- i_fifo_get  in  1  from fifo o_get (pop ack).
- i_fifo_data  in  WIDTH  from fifo o_data.

Behaviour:
- Reset (async): state = IDLE; all outputs 0 except o_empty = 1; priority pointer = requester 0; o_fault = 0; timeout counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- Eligibility: requester n is eligible when i_req[n] = 1 and o_ack[n] = 0 and o_err[n] = 0. This guard mirrors the FIFO's own ack guard.
- IDLE, with i_en = 1 and at least one eligible requester:
  - Grant by round robin: the pointer's requester wins if eligible, otherwise the other one. After any grant, the pointer moves to the non-granted requester.
  - Granted op illegal (push with o_full, or pop with o_empty): go to DONE with the error flag set. The FIFO is not touched.
  - Otherwise: latch requester index, op and wdata; go to ISSUE.
- IDLE, with i_en = 0: stay in IDLE and ignore requests.
- ISSUE (exactly 1 cycle):
  - Drive o_fifo_set (push) or o_fifo_get (pop) high, with o_fifo_data = latched wdata.
  - Go to WAIT. Strobes are low in every other state.
- WAIT:
  - On i_fifo_set (push) or i_fifo_get (pop): capture i_fifo_data (pop only), update count (+1 push, -1 pop), go to DONE.
  - Timeout counter increments each WAIT cycle. On reaching TIMEOUT with no ack: set o_fault, set the error flag, count unchanged, go to DONE.
- DONE (1 cycle):
  - Pulse o_ack[granted] on success, or o_err[granted] on error/timeout.
  - o_rdata updates in this cycle for a successful pop only.
  - Go to IDLE.
- Nominal latency: request sampled at edge 0 → ISSUE in cycle 1 → ack seen in WAIT in cycle 2 → o_ack in cycle 3 → IDLE in cycle 4. Throughput is one transaction per 4 cycles.
- Rejection latency: o_err asserted in the cycle after the IDLE sample.
- An in-flight transaction always completes, even if i_en drops mid-transaction.
- If a requester drops i_req mid-transaction, the transaction still completes and the pulse is still issued.
- Count never wraps: the full/empty checks guarantee 0 <= o_count <= DEPTH.
- o_full and o_empty are combinational from o_count.
- A FIFO ack arriving outside WAIT is ignored.
- Reset mid-transaction: returns to IDLE immediately and clears the count. The FIFO shares i_rst, so the two stay consistent.

Test Plan:
- Push then pop (DEPTH = 4): r0 pushes 0x5A → o_ack[0] 3 cycles after the request edge, o_count = 1; r0 pops → o_rdata = 0x5A, o_count = 0, o_empty = 1.
- Pop when empty: r1 pops after reset → o_err[1] next cycle; o_fifo_get never asserts; o_count stays 0.
- Fill and overflow: push 0x01..0x04 → o_full = 1, o_count = 4; fifth push → o_err; pops return 0x01, 0x02, 0x03, 0x04 in order.
- Contention: r0 and r1 both hold push requests continuously → grants alternate r0, r1, r0, r1; each requester gets one o_ack per 8 cycles.
- Timeout: tie i_fifo_set to 0 and issue a push → o_err 15 cycles after WAIT entry; o_fault = 1 and stays set; o_count unchanged.
- Reset mid-transaction: assert i_rst during WAIT → all outputs at reset values asynchronously; a new push afterwards completes normally.
